// File: rtl/m_turn_scheduler.sv
// m_turn_scheduler: connect-four turn sequencer, move arbiter and 4-cycle sequential win checker.
// Optional macro SCHED_TIMEOUT_EN enables an automatic move after TIMEOUT_CYCLES idle turn cycles.
module m_turn_scheduler #(
  parameter logic [31:0]        TIMEOUT_CYCLES = 32'd100_000_000,
  localparam int unsigned       COL_SIZE       = 3,
  localparam int unsigned       FIELD_SIZE     = 42
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  i_restart,
  input  logic                  i_red_req,
  input  logic [COL_SIZE-1:0]   i_red_col,
  input  logic                  i_blue_req,
  input  logic [COL_SIZE-1:0]   i_blue_col,
  output logic                  o_red_ack,
  output logic                  o_blue_ack,
  output logic                  o_red_nack,
  output logic                  o_blue_nack,
  output logic [FIELD_SIZE-1:0] o_red_field,
  output logic [FIELD_SIZE-1:0] o_blue_field,
  output logic                  o_turn,
  output logic                  o_busy,
  output logic [1:0]            o_winner,
  output logic                  o_game_over,
  output logic [5:0]            o_move_count
);
  localparam int unsigned NUM_COLS  = 7;
  localparam int unsigned NUM_ROWS  = 6;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned PILE_SIZE = NUM_COLS * CNT_W;

  typedef enum logic [1:0] {
    ST_RED_TURN  = 2'd0,
    ST_BLUE_TURN = 2'd1,
    ST_CHECK     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FIELD_SIZE-1:0] r_red_field;
  logic [FIELD_SIZE-1:0] r_blue_field;
  logic [PILE_SIZE-1:0]  r_piled;
  logic [5:0]            r_move_cnt;
  logic                  r_red_ack;
  logic                  r_blue_ack;
  logic                  r_red_nack;
  logic                  r_blue_nack;
  logic [1:0]            r_winner;
  logic [1:0]            r_dir;
  logic                  r_win;
  logic [COL_SIZE-1:0]   r_col;
  logic [CNT_W-1:0]      r_row;
  logic                  r_turn;

  logic                  w_in_turn;
  logic                  w_is_blue;
  logic                  w_req;
  logic                  w_auto;
  logic [COL_SIZE-1:0]   w_auto_col;
  logic [COL_SIZE-1:0]   w_sel_col;
  logic [CNT_W-1:0]      w_pile_cnt;
  logic                  w_valid;
  logic [FIELD_SIZE-1:0] w_cur_field;
  logic [FIELD_SIZE-1:0] w_new_field;
  logic [FIELD_SIZE-1:0] w_mover_field;
  logic [PILE_SIZE-1:0]  w_new_piled;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_dir_win;
  logic                  w_final_win;
  int                    w_dc;
  int                    w_dr;
  int                    w_total;
  logic                  w_run_pos;
  logic                  w_run_neg;

  assign w_in_turn     = (r_state == ST_RED_TURN) || (r_state == ST_BLUE_TURN);
  assign w_is_blue     = (r_state == ST_BLUE_TURN);
  assign w_cur_field   = w_is_blue ? r_blue_field : r_red_field;
  assign w_mover_field = r_turn ? r_blue_field : r_red_field;
  assign w_sel_col     = w_auto ? w_auto_col : (w_is_blue ? i_blue_col : i_red_col);

  // Only the current player's request counts, and never while its ack/nack is still showing.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      ST_RED_TURN:  w_req = i_red_req & ~r_red_ack & ~r_red_nack;
      ST_BLUE_TURN: w_req = i_blue_req & ~r_blue_ack & ~r_blue_nack;
      default:      w_req = 1'b0;
    endcase
  end

`ifdef SCHED_TIMEOUT_EN
  logic [31:0] r_to_cnt;

  // Lowest-indexed column that still has room.
  always_comb begin
    w_auto_col = '0;
    for (int c = int'(NUM_COLS) - 1; c >= 0; c--) begin
      if (r_piled[c*CNT_W +: CNT_W] < CNT_W'(NUM_ROWS)) w_auto_col = COL_SIZE'(c);
    end
  end

  assign w_auto = w_in_turn & ~w_req & (r_to_cnt >= TIMEOUT_CYCLES);

  always_ff @(posedge w_clk) begin
    if (w_rst || i_restart || !w_in_turn || w_accept || w_reject) r_to_cnt <= '0;
    else                                                           r_to_cnt <= r_to_cnt + 32'd1;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_auto           = 1'b0;
  assign w_auto_col       = '0;
`endif

  // Piler: drop a disc into the selected column of the current player's field.
  always_comb begin
    w_pile_cnt  = '0;
    w_new_piled = r_piled;
    for (int c = 0; c < int'(NUM_COLS); c++) begin
      if (w_sel_col == COL_SIZE'(c)) begin
        w_pile_cnt                    = r_piled[c*CNT_W +: CNT_W];
        w_new_piled[c*CNT_W +: CNT_W] = r_piled[c*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
    w_valid     = (w_sel_col < COL_SIZE'(NUM_COLS)) && (w_pile_cnt < CNT_W'(NUM_ROWS));
    w_new_field = w_cur_field |
                  (FIELD_SIZE'(1) << (int'(w_pile_cnt) * int'(NUM_COLS) + int'(w_sel_col)));
  end

  function automatic logic f_cell(input logic [FIELD_SIZE-1:0] f, input int row, input int col);
    logic v;
    v = 1'b0;
    if (row >= 0 && row < int'(NUM_ROWS) && col >= 0 && col < int'(NUM_COLS))
      v = f[6'(row * int'(NUM_COLS) + col)];
    return v;
  endfunction

  // One direction per CHECK cycle: contiguous run through the placed cell, clipped at edges.
  always_comb begin
    w_dc = 1;
    w_dr = 0;
    case (r_dir)
      2'd0:    begin w_dc = 1; w_dr = 0;  end
      2'd1:    begin w_dc = 0; w_dr = 1;  end
      2'd2:    begin w_dc = 1; w_dr = 1;  end
      default: begin w_dc = 1; w_dr = -1; end
    endcase
    w_total   = 1;
    w_run_pos = 1'b1;
    w_run_neg = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (w_run_pos && f_cell(w_mover_field, int'(r_row) + k*w_dr, int'(r_col) + k*w_dc))
        w_total = w_total + 1;
      else
        w_run_pos = 1'b0;
      if (w_run_neg && f_cell(w_mover_field, int'(r_row) - k*w_dr, int'(r_col) - k*w_dc))
        w_total = w_total + 1;
      else
        w_run_neg = 1'b0;
    end
    w_dir_win = (w_total >= 4);
  end

  // Next-state and move strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = w_in_turn & w_valid & (w_req | w_auto);
    w_reject    = w_in_turn & w_req & ~w_valid;
    w_final_win = r_win | w_dir_win;
    case (r_state)
      ST_RED_TURN, ST_BLUE_TURN: begin
        if (w_accept) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (r_dir == 2'd3) begin
          if (w_final_win || r_move_cnt == 6'd42) w_state_nxt = ST_GAME_OVER;
          else                                    w_state_nxt = r_turn ? ST_RED_TURN : ST_BLUE_TURN;
        end
      end
      default: w_state_nxt = ST_GAME_OVER;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst || i_restart) r_state <= ST_RED_TURN;
    else                    r_state <= w_state_nxt;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst || i_restart) begin
      r_red_field  <= '0;
      r_blue_field <= '0;
      r_piled      <= '0;
      r_move_cnt   <= '0;
      r_red_ack    <= 1'b0;
      r_blue_ack   <= 1'b0;
      r_red_nack   <= 1'b0;
      r_blue_nack  <= 1'b0;
      r_winner     <= 2'b00;
      r_dir        <= 2'd0;
      r_win        <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_turn       <= 1'b0;
    end else begin
      r_red_ack   <= w_accept & w_req & ~w_is_blue;
      r_blue_ack  <= w_accept & w_req & w_is_blue;
      r_red_nack  <= w_reject & ~w_is_blue;
      r_blue_nack <= w_reject & w_is_blue;
      if (w_accept) begin
        if (w_is_blue) r_blue_field <= w_new_field;
        else           r_red_field  <= w_new_field;
        r_piled    <= w_new_piled;
        r_col      <= w_sel_col;
        r_row      <= w_pile_cnt;
        r_move_cnt <= r_move_cnt + 6'd1;
        r_dir      <= 2'd0;
        r_win      <= 1'b0;
      end
      if (r_state == ST_CHECK) begin
        r_dir <= r_dir + 2'd1;
        if (w_dir_win) r_win <= 1'b1;
        if (r_dir == 2'd3) begin
          if (w_final_win)              r_winner <= r_turn ? 2'b10 : 2'b01;
          else if (r_move_cnt == 6'd42) r_winner <= 2'b11;
          else                          r_turn   <= ~r_turn;
        end
      end
    end
  end

  assign o_red_ack    = r_red_ack;
  assign o_blue_ack   = r_blue_ack;
  assign o_red_nack   = r_red_nack;
  assign o_blue_nack  = r_blue_nack;
  assign o_red_field  = r_red_field;
  assign o_blue_field = r_blue_field;
  assign o_turn       = r_turn;
  assign o_busy       = (r_state == ST_CHECK);
  assign o_winner     = r_winner;
  assign o_game_over  = (r_state == ST_GAME_OVER);
  assign o_move_count = r_move_cnt;
endmodule
